// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// Holds a committed frame (four hex nibbles, per-digit DP and blank flags,
// brightness), walks the anodes one digit at a time, and applies PWM
// brightness inside each digit slot. New frames arrive through LOAD/READY
// and only commit at the end of the digit 3 slot, so the display never tears.
//
// Ports:
//   CLK100MHZ  - system clock, all state on the rising edge
//   RESET      - asynchronous active-high reset
//   DATA       - digit i nibble is DATA[4i+3:4i]
//   DP_IN      - DP_IN[i]=1 lights the decimal point of digit i
//   BLANK      - BLANK[i]=1 keeps digit i dark
//   BRIGHT     - duty level for the frame (phase < BRIGHT is lit)
//   LOAD       - producer offers DATA/DP_IN/BLANK/BRIGHT
//   READY      - pending slot empty; transfer when LOAD && READY
//   FRAME_DONE - one-cycle pulse after each commit point
//   AN         - active-low anodes, at most one low
//   SEG        - active-low segments, SEG[0]=a .. SEG[6]=g
//   DP         - active-low decimal point
module seven_seg_scan_ctrl #(
  parameter int unsigned DIV_WIDTH = 12,
  parameter int unsigned BR_WIDTH  = 4
) (
  input  logic                CLK100MHZ,
  input  logic                RESET,
  input  logic [15:0]         DATA,
  input  logic [3:0]          DP_IN,
  input  logic [3:0]          BLANK,
  input  logic [BR_WIDTH-1:0] BRIGHT,
  input  logic                LOAD,
  output logic                READY,
  output logic                FRAME_DONE,
  output logic [3:0]          AN,
  output logic [6:0]          SEG,
  output logic                DP
);

  localparam int unsigned NUM_DIG = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DATA_W  = NUM_DIG * NIB_W;

  // Scan counters
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [BR_WIDTH-1:0]  phase_q, phase_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  // Active (displayed) frame
  logic [DATA_W-1:0]    act_data_q, act_data_d;
  logic [NUM_DIG-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIG-1:0]   act_blank_q, act_blank_d;
  logic [BR_WIDTH-1:0]  act_bright_q, act_bright_d;

  // Pending frame; ready_q=1 means the slot is empty
  logic [DATA_W-1:0]    pend_data_q, pend_data_d;
  logic [NUM_DIG-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIG-1:0]   pend_blank_q, pend_blank_d;
  logic [BR_WIDTH-1:0]  pend_bright_q, pend_bright_d;
  logic                 ready_q, ready_d;

  // Registered outputs
  logic                 frame_done_q, frame_done_d;
  logic [NUM_DIG-1:0]   an_q, an_d;
  logic [SEG_W-1:0]     seg_q, seg_d;
  logic                 dp_q, dp_d;

  logic                 tick_c;
  logic                 phase_max_c;
  logic                 commit_c;
  logic                 lit_c;
  logic [NIB_W-1:0]     nib_c;
  logic [SEG_W-1:0]     dec_c;

  assign tick_c      = (presc_q == {DIV_WIDTH{1'b1}});
  assign phase_max_c = (phase_q == {BR_WIDTH{1'b1}});
  assign commit_c    = tick_c && phase_max_c && (idx_q == IDX_W'(NUM_DIG - 1));

  // Prescaler, PWM phase and digit index
  always_comb begin
    presc_d = presc_q + DIV_WIDTH'(1);
    phase_d = phase_q;
    idx_d   = idx_q;
    if (tick_c) begin
      phase_d = phase_q + BR_WIDTH'(1);
      if (phase_max_c) begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Handshake and frame commit. A load accepted on a commit cycle with an
  // empty slot only fills pending; it waits for the next commit point.
  always_comb begin
    act_data_d    = act_data_q;
    act_dp_d      = act_dp_q;
    act_blank_d   = act_blank_q;
    act_bright_d  = act_bright_q;
    pend_data_d   = pend_data_q;
    pend_dp_d     = pend_dp_q;
    pend_blank_d  = pend_blank_q;
    pend_bright_d = pend_bright_q;
    ready_d       = ready_q;
    if (LOAD && ready_q) begin
      pend_data_d   = DATA;
      pend_dp_d     = DP_IN;
      pend_blank_d  = BLANK;
      pend_bright_d = BRIGHT;
      ready_d       = 1'b0;
    end
    if (commit_c && !ready_q) begin
      act_data_d   = pend_data_q;
      act_dp_d     = pend_dp_q;
      act_blank_d  = pend_blank_q;
      act_bright_d = pend_bright_q;
      ready_d      = 1'b1;
    end
  end

  // Hex to active-low segment decode of the current digit
  assign nib_c = act_data_q[{idx_q, 2'b00} +: NIB_W];

  always_comb begin
    dec_c = 7'h7F;
    case (nib_c)
      4'h0: dec_c = 7'h40;
      4'h1: dec_c = 7'h79;
      4'h2: dec_c = 7'h24;
      4'h3: dec_c = 7'h30;
      4'h4: dec_c = 7'h19;
      4'h5: dec_c = 7'h12;
      4'h6: dec_c = 7'h02;
      4'h7: dec_c = 7'h78;
      4'h8: dec_c = 7'h00;
      4'h9: dec_c = 7'h10;
      4'hA: dec_c = 7'h08;
      4'hB: dec_c = 7'h03;
      4'hC: dec_c = 7'h46;
      4'hD: dec_c = 7'h21;
      4'hE: dec_c = 7'h06;
      4'hF: dec_c = 7'h0E;
      default: dec_c = 7'h7F;
    endcase
  end

  // Display drive for the next cycle
  assign lit_c = !act_blank_q[idx_q] && (phase_q < act_bright_q);

  always_comb begin
    frame_done_d = commit_c;
    an_d         = 4'hF;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    if (lit_c) begin
      an_d  = ~(NUM_DIG'(1) << idx_q);
      seg_d = dec_c;
      dp_d  = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      presc_q       <= '0;
      phase_q       <= '0;
      idx_q         <= '0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      act_bright_q  <= '1;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '0;
      pend_bright_q <= '0;
      ready_q       <= 1'b1;
      frame_done_q  <= 1'b0;
      an_q          <= 4'hF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
    end else begin
      presc_q       <= presc_d;
      phase_q       <= phase_d;
      idx_q         <= idx_d;
      act_data_q    <= act_data_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      act_bright_q  <= act_bright_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_bright_q <= pend_bright_d;
      ready_q       <= ready_d;
      frame_done_q  <= frame_done_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign READY      = ready_q;
  assign FRAME_DONE = frame_done_q;
  assign AN         = an_q;
  assign SEG        = seg_q;
  assign DP         = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with DIV_WIDTH=2, BR_WIDTH=2
// (4 clocks per phase, 16 per digit slot, 64 per frame).
module tb_seven_seg_scan_ctrl;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [1:0]  bright;
  } frame_t;

  typedef struct packed {
    frame_t          f;
    logic [3:0][7:0] exp_lit;   // lit clocks per digit over one frame
    logic [3:0][6:0] exp_seg;   // segment pattern while lit
    logic [3:0]      exp_dp;    // DP pin level while lit
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ready;
    logic       fd;
  } exp_t;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        CLK100MHZ = 1'b0;
  logic        RESET     = 1'b1;
  logic [15:0] DATA      = '0;
  logic [3:0]  DP_IN     = '0;
  logic [3:0]  BLANK     = '0;
  logic [1:0]  BRIGHT    = '0;
  logic        LOAD      = 1'b0;
  logic        READY;
  logic        FRAME_DONE;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t   exp_q[$];
  int     m_cnt;
  frame_t m_act, m_pend;
  logic   m_ready;

  seven_seg_scan_ctrl #(.DIV_WIDTH(2), .BR_WIDTH(2)) dut (
    .CLK100MHZ (CLK100MHZ),
    .RESET     (RESET),
    .DATA      (DATA),
    .DP_IN     (DP_IN),
    .BLANK     (BLANK),
    .BRIGHT    (BRIGHT),
    .LOAD      (LOAD),
    .READY     (READY),
    .FRAME_DONE(FRAME_DONE),
    .AN        (AN),
    .SEG       (SEG),
    .DP        (DP)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Reference model: frame position from a cycle count since reset release
  initial begin
    forever begin
      @(posedge CLK100MHZ or posedge RESET);
      if (RESET) begin
        m_cnt   = 0;
        m_act   = '{data: 16'h0, dp: 4'h0, blank: 4'hF, bright: 2'd3};
        m_pend  = '0;
        m_ready = 1'b1;
        exp_q.delete();
      end else begin
        int p, d, ph;
        logic lit, commit, nr;
        logic [15:0] sh;
        exp_t e;
        p  = m_cnt % 64;
        d  = p / 16;
        ph = (p / 4) % 4;
        lit = !m_act.blank[d] && (ph < int'(m_act.bright));
        sh  = m_act.data >> (4 * d);
        e.an  = lit ? ~(4'b0001 << d) : 4'hF;
        e.seg = lit ? SEG_LUT[sh[3:0]] : 7'h7F;
        e.dp  = lit ? ~m_act.dp[d] : 1'b1;
        commit = (p == 63);
        nr = m_ready;
        if (LOAD && m_ready) begin
          m_pend = '{data: DATA, dp: DP_IN, blank: BLANK, bright: BRIGHT};
          nr = 1'b0;
        end
        if (commit && !m_ready) begin
          m_act = m_pend;
          nr = 1'b1;
        end
        m_ready = nr;
        e.ready = nr;
        e.fd    = commit;
        exp_q.push_back(e);
        m_cnt++;
      end
    end
  end

  // Scoreboard compare, away from the active edge
  initial begin
    forever begin
      @(negedge CLK100MHZ);
      if (!RESET && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("scoreboard {an,seg,dp,ready,fd}", 32'({AN, SEG, DP, READY, FRAME_DONE}), 32'(e));
      end
    end
  end

  function automatic vec_t mkvec(input logic [15:0] data, input logic [3:0] dp,
                                 input logic [3:0] blank, input logic [1:0] bright,
                                 input logic [3:0][7:0] lit, input logic [3:0][6:0] seg,
                                 input logic [3:0] dpx);
    vec_t v;
    v.f       = '{data: data, dp: dp, blank: blank, bright: bright};
    v.exp_lit = lit;
    v.exp_seg = seg;
    v.exp_dp  = dpx;
    return v;
  endfunction

  task automatic drive_frame(input frame_t f);
    DATA   = f.data;
    DP_IN  = f.dp;
    BLANK  = f.blank;
    BRIGHT = f.bright;
  endtask

  task automatic load_frame(input frame_t f);
    int k = 0;
    while (!READY && k < 200) begin
      @(negedge CLK100MHZ);
      k++;
    end
    check("load_wait_ready", 32'(READY), 32'(1));
    drive_frame(f);
    LOAD = 1'b1;
    @(negedge CLK100MHZ);
    LOAD = 1'b0;
    check("load_ready_drop", 32'(READY), 32'(0));
  endtask

  task automatic wait_commit();
    int k = 0;
    do begin
      @(negedge CLK100MHZ);
      k++;
    end while (!(READY && FRAME_DONE) && k < 300);
    check("commit_seen", 32'(READY && FRAME_DONE), 32'(1));
  endtask

  task automatic observe(input vec_t v, input string tag);
    logic [3:0][7:0] lit;
    logic [3:0][6:0] sg;
    logic [3:0]      dpv;
    int d;
    lit = '0;
    sg  = {4{7'h7F}};
    dpv = '1;
    repeat (64) begin
      @(negedge CLK100MHZ);
      case (AN)
        4'hE: d = 0;
        4'hD: d = 1;
        4'hB: d = 2;
        4'h7: d = 3;
        default: d = -1;
      endcase
      if (d >= 0) begin
        lit[d] = lit[d] + 8'd1;
        sg[d]  = SEG;
        dpv[d] = DP;
      end
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_lit%0d", tag, i), 32'(lit[i]), 32'(v.exp_lit[i]));
      if (v.exp_lit[i] != 8'd0) begin
        check($sformatf("%s_seg%0d", tag, i), 32'(sg[i]), 32'(v.exp_seg[i]));
        check($sformatf("%s_dp%0d", tag, i), 32'(dpv[i]), 32'(v.exp_dp[i]));
      end
    end
  endtask

  vec_t vecs[6];
  vec_t vb, vc;

  initial begin
    int k;
    vecs[0] = mkvec(16'h3210, 4'b0100, 4'h0, 2'd3, {8'd12, 8'd12, 8'd12, 8'd12},
                    {7'h30, 7'h24, 7'h79, 7'h40}, 4'b1011);
    vecs[1] = mkvec(16'h9876, 4'b0000, 4'h0, 2'd0, {8'd0, 8'd0, 8'd0, 8'd0},
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111);
    vecs[2] = mkvec(16'hABCD, 4'b1111, 4'hF, 2'd3, {8'd0, 8'd0, 8'd0, 8'd0},
                    {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111);
    vecs[3] = mkvec(16'hFEDC, 4'b1000, 4'b0010, 2'd2, {8'd8, 8'd8, 8'd0, 8'd8},
                    {7'h0E, 7'h06, 7'h7F, 7'h46}, 4'b0111);
    vecs[4] = mkvec(16'h8765, 4'b0000, 4'h0, 2'd1, {8'd4, 8'd4, 8'd4, 8'd4},
                    {7'h00, 7'h78, 7'h02, 7'h12}, 4'b1111);
    vecs[5] = mkvec(16'hB9A4, 4'b1111, 4'h0, 2'd3, {8'd12, 8'd12, 8'd12, 8'd12},
                    {7'h03, 7'h10, 7'h08, 7'h19}, 4'b0000);
    vb = mkvec(16'hC0DE, 4'b0001, 4'h0, 2'd3, {8'd12, 8'd12, 8'd12, 8'd12},
               {7'h46, 7'h40, 7'h21, 7'h06}, 4'b1110);
    vc = mkvec(16'h4567, 4'b0001, 4'h0, 2'd3, {8'd12, 8'd12, 8'd12, 8'd12},
               {7'h19, 7'h12, 7'h02, 7'h78}, 4'b1110);

    // Reset state
    repeat (3) @(negedge CLK100MHZ);
    check("rst_an", 32'(AN), 32'(4'hF));
    check("rst_seg", 32'(SEG), 32'(7'h7F));
    check("rst_dp", 32'(DP), 32'(1));
    check("rst_ready", 32'(READY), 32'(1));
    check("rst_fd", 32'(FRAME_DONE), 32'(0));
    RESET = 1'b0;

    // Idle: FRAME_DONE period
    k = 0;
    do begin @(negedge CLK100MHZ); k++; end while (!FRAME_DONE && k < 200);
    check("fd_first", 32'(FRAME_DONE), 32'(1));
    k = 0;
    do begin @(negedge CLK100MHZ); k++; end while (!FRAME_DONE && k < 200);
    check("fd_period", 32'(k), 32'(64));

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      load_frame(vecs[i].f);
      wait_commit();
      observe(vecs[i], $sformatf("vec%0d", i));
    end

    // LOAD held while READY=0: accepted the cycle after READY rises
    load_frame(vecs[0].f);
    drive_frame(vb.f);
    LOAD = 1'b1;
    k = 0;
    while (!READY && k < 200) begin
      @(negedge CLK100MHZ);
      k++;
    end
    check("held_commit_fd", 32'(FRAME_DONE), 32'(1));
    @(negedge CLK100MHZ);
    check("held_accept", 32'(READY), 32'(0));
    LOAD = 1'b0;
    wait_commit();
    observe(vb, "held");

    // LOAD exactly on the commit cycle with pending empty
    k = 0;
    while ((m_cnt % 64) != 63 && k < 200) begin
      @(negedge CLK100MHZ);
      k++;
    end
    drive_frame(vc.f);
    LOAD = 1'b1;
    @(negedge CLK100MHZ);
    LOAD = 1'b0;
    check("cload_fd", 32'(FRAME_DONE), 32'(1));
    check("cload_ready", 32'(READY), 32'(0));
    wait_commit();
    observe(vc, "cload");

    // Reset mid digit 2 with pending full
    load_frame(vecs[4].f);
    k = 0;
    while ((m_cnt % 64) != 40 && k < 200) begin
      @(negedge CLK100MHZ);
      k++;
    end
    check("pre_rst_an", 32'(AN), 32'(4'hB));
    #1 RESET = 1'b1;
    #1;
    check("mid_rst_an", 32'(AN), 32'(4'hF));
    check("mid_rst_seg", 32'(SEG), 32'(7'h7F));
    check("mid_rst_dp", 32'(DP), 32'(1));
    check("mid_rst_ready", 32'(READY), 32'(1));
    @(negedge CLK100MHZ);
    RESET = 1'b0;
    @(negedge CLK100MHZ);
    check("post_rst_ready", 32'(READY), 32'(1));
    load_frame(vecs[5].f);
    wait_commit();
    k = 0;
    do begin @(negedge CLK100MHZ); k++; end while (AN == 4'hF && k < 64);
    check("post_rst_first_an", 32'(AN), 32'(4'hE));
    check("post_rst_first_seg", 32'(SEG), 32'(7'h19));

    repeat (4) @(negedge CLK100MHZ);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit common-anode seven-segment display on the 100 MHz board clock.
- Holds a committed frame of four hex nibbles with per-digit decimal-point and blank flags.
- Walks the anodes one digit at a time and decodes each nibble to active-low segments.
- Applies PWM brightness inside each digit slot.
- Producers hand over new frames through a LOAD/READY handshake. A frame commits only at a scan-frame boundary, so the display never tears.

Parameters:
DIV_WIDTH, 12, prescaler width; one phase tick every 2^DIV_WIDTH clocks (min 1).
BR_WIDTH, 4, brightness/phase counter width; one digit slot = 2^BR_WIDTH ticks.

Ports:
CLK100MHZ  in  1  system clock; all state on rising edge.
RESET  in  1  asynchronous, active-high reset.
DATA  in  16  digit i nibble = DATA[4i+3:4i].
DP_IN  in  4  DP_IN[i]=1 lights decimal point of digit i.
BLANK  in  4  BLANK[i]=1 keeps digit i dark.
BRIGHT  in  BR_WIDTH  duty level for the frame.
LOAD  in  1  producer offers DATA/DP_IN/BLANK/BRIGHT.
READY  out  1  pending slot empty; transfer occurs when LOAD && READY.
FRAME_DONE  out  1  one-cycle pulse at each commit point (end of digit 3 slot).
AN  out  4  active-low anodes, at most one low.
SEG  out  7  active-low segments, SEG[0]=a … SEG[6]=g.
DP  out  1  active-low decimal point.

Behaviour:
- Reset (async) values:
  - AN=4'hF, SEG=7'h7F, DP=1.
  - Prescaler=0, phase=0, digit index=0.
  - Active frame: DATA=0, DP=0, BLANK=4'hF, BRIGHT=all ones.
  - Pending empty, READY=1, FRAME_DONE=0.
- Counters:
  - tick: prescaler wraps at 2^DIV_WIDTH-1.
  - phase: increments on tick.
  - digit index: increments (mod 4) on tick when phase = max.
- Commit point: cycle where tick && phase=max && index=3.
  - FRAME_DONE=1 for exactly that cycle, registered, visible the following cycle.
- Handshake:
  - LOAD && READY captures inputs into the pending register. READY=0 from the next cycle.
  - LOAD while READY=0 is ignored; the producer holds LOAD.
  - At the commit point, if pending is full: pending → active, READY=1 next cycle.
  - LOAD accepted in the same cycle as a commit with pending empty stays pending until the next frame. No bypass.
- Digit output:
  - For current index i, digit is lit when BLANK[i]=0 and phase < BRIGHT (BRIGHT=0 → dark; max → (2^BR_WIDTH-1)/2^BR_WIDTH duty).
  - Lit: AN = ~(1<<i), SEG = decode(nibble i), DP = ~DP_IN[i].
  - Dark: AN=4'hF, SEG=7'h7F, DP=1.
- Latency: AN/SEG/DP are registered, one clock after the state they reflect.
- Decode (hex, SEG[6:0]): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Invariants:
  - Active frame changes only at a commit point.
  - AN never has more than one zero bit.
- Reset mid-operation: pending is dropped and the display goes dark immediately (async). Scan restarts at digit 0, phase 0.

Test Plan:
- Reset then idle, DIV_WIDTH=2, BR_WIDTH=2 → AN=F, SEG=7F, DP=1, READY=1. FRAME_DONE pulses every 64 clocks.
- LOAD DATA=16'h3210, DP_IN=4'b0100, BLANK=0, BRIGHT=3 → READY=0 until the first commit. Next frame shows:
  - AN E/SEG 40, AN D/SEG 79, AN B/SEG 24 with DP=0, AN 7/SEG 30.
  - Each digit lit 12 of 16 clocks.
- Second LOAD held while READY=0 → not accepted. Accepted the cycle after READY rises. Shown one frame later; no frame mixes old and new nibbles.
- BRIGHT=0 or BLANK=4'hF → AN stays F for a full frame. BLANK=4'b0010 → only digit 1 dark.
- LOAD asserted exactly on the commit cycle with pending empty → captured, committed at the following commit point.
- RESET pulsed mid-digit-2 with pending full → outputs dark the same cycle. After release READY=1, scan restarts at AN=E once a frame is loaded.
